cordic_cos_arbiter: RTL

CORDIC_COS_ARBITER -- requirements
Module: cordic_cos_arbiter

---
 rtl/cordic_cos_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cordic_cos_arbiter.sv
// cordic_cos_arbiter: round-robin front end that shares one external CORDIC
// cosine pipeline between two requesters. Each issued angle carries a
// {valid, id} tag down a LATENCY-deep shift register that advances in lockstep
// with the pipeline, so the result leaving the pipeline is routed back to the
// requester that issued it. The pipeline only freezes when no tag is in
// flight, which means no result can be lost.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   reqN_valid/angle/ready       request handshake (ready is a combinational grant)
//   cordic_enable/angle          advance enable and angle to the shared pipeline
//   cordic_cos                   pipeline result, aligned with the exiting tag
//   rspN_valid/cos               one-cycle registered result pulse per requester
//   busy                         any tag in flight
//   issue_count, conflict_count  16-bit wrapping statistics, present only when
//                                CORDIC_ARB_STATS_EN is defined
module cordic_cos_arbiter #(
    parameter int unsigned LATENCY = 17,
    parameter int unsigned WIDTH   = 22
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_angle,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_angle,
    output logic             req1_ready,
    output logic             cordic_enable,
    output logic [WIDTH-1:0] cordic_angle,
    input  logic [WIDTH-1:0] cordic_cos,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_cos,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_cos,
    output logic             busy
`ifdef CORDIC_ARB_STATS_EN
    ,
    output logic [15:0]      issue_count,
    output logic [15:0]      conflict_count
`endif
);

    localparam int unsigned CNT_W = 16;

    // prio_q = 0: req0 wins a tie; 1: req1 wins a tie
    logic prio_q, prio_d;

    logic [LATENCY-1:0] tag_valid_q, tag_valid_d;
    logic [LATENCY-1:0] tag_id_q, tag_id_d;

    logic             busy_q, busy_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp0_cos_q, rsp0_cos_d;
    logic [WIDTH-1:0] rsp1_cos_q, rsp1_cos_d;

    logic grant0_c, grant1_c, grant_c, grant_id_c;
    logic exit_valid_c, exit_id_c;

    // Round-robin grant; suppressed while reset is asserted so the pipeline
    // interface is quiet as soon as reset goes low.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (reset_n) begin
            if (req0_valid && (!req1_valid || !prio_q)) begin
                grant0_c = 1'b1;
            end else if (req1_valid) begin
                grant1_c = 1'b1;
            end
        end
    end

    assign grant_c    = grant0_c | grant1_c;
    assign grant_id_c = grant1_c;

    assign req0_ready    = grant0_c;
    assign req1_ready    = grant1_c;
    assign cordic_enable = grant_c | busy_q;
    assign cordic_angle  = grant1_c ? req1_angle :
                           grant0_c ? req0_angle : '0;

    // The oldest tag lines up with cordic_cos on the current cycle.
    assign exit_valid_c = tag_valid_q[LATENCY-1] & cordic_enable;
    assign exit_id_c    = tag_id_q[LATENCY-1];

    // Next-state: pointer, tag shift register, busy and response registers.
    always_comb begin
        prio_d       = prio_q;
        tag_valid_d  = tag_valid_q;
        tag_id_d     = tag_id_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_cos_d   = rsp0_cos_q;
        rsp1_cos_d   = rsp1_cos_q;

        if (grant_c) begin
            prio_d = ~grant_id_c;
        end

        if (cordic_enable) begin
            tag_valid_d = {tag_valid_q[LATENCY-2:0], grant_c};
            tag_id_d    = {tag_id_q[LATENCY-2:0], grant_id_c};
        end

        if (exit_valid_c) begin
            if (exit_id_c) begin
                rsp1_valid_d = 1'b1;
                rsp1_cos_d   = cordic_cos;
            end else begin
                rsp0_valid_d = 1'b1;
                rsp0_cos_d   = cordic_cos;
            end
        end

        // Registered copy of "any tag valid" taken from the next tag state.
        busy_d = |tag_valid_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q       <= 1'b0;
            tag_valid_q  <= '0;
            tag_id_q     <= '0;
            busy_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_cos_q   <= '0;
            rsp1_cos_q   <= '0;
        end else begin
            prio_q       <= prio_d;
            tag_valid_q  <= tag_valid_d;
            tag_id_q     <= tag_id_d;
            busy_q       <= busy_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_cos_q   <= rsp0_cos_d;
            rsp1_cos_q   <= rsp1_cos_d;
        end
    end

    assign busy       = busy_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_cos   = rsp0_cos_q;
    assign rsp1_cos   = rsp1_cos_q;

`ifdef CORDIC_ARB_STATS_EN
    logic [CNT_W-1:0] issue_count_q, issue_count_d;
    logic [CNT_W-1:0] conflict_count_q, conflict_count_d;

    // Wrapping grant and contention counters.
    always_comb begin
        issue_count_d    = issue_count_q + CNT_W'(grant_c);
        conflict_count_d = conflict_count_q + CNT_W'(req0_valid & req1_valid);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_count_q    <= '0;
            conflict_count_q <= '0;
        end else begin
            issue_count_q    <= issue_count_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    assign issue_count    = issue_count_q;
    assign conflict_count = conflict_count_q;
`endif

endmodule
